// File: rtl/kb_cmd_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : kb_cmd_decoder                                                |
// | Purpose  : PS/2 scancode set-2 decoder producing game commands           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module kb_cmd_decoder #(
  parameter int TIMEOUT = 1250000
) (
  input  logic       VGA_clk,
  input  logic       reset,
  input  logic [7:0] code,
  output logic       jump_pulse,
  output logic       duck_hold,
  output logic       start_pulse,
  output logic       pause
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  localparam logic [7:0]  c_BYTE_EXT     = 8'hE0;
  localparam logic [7:0]  c_BYTE_BRK     = 8'hF0;
  localparam logic [7:0]  c_KEY_SPACE    = 8'h29;
  localparam logic [7:0]  c_KEY_UP       = 8'h75;
  localparam logic [7:0]  c_KEY_DOWN     = 8'h72;
  localparam logic [7:0]  c_KEY_ENTER    = 8'h5A;
  localparam logic [7:0]  c_KEY_P        = 8'h4D;
  localparam logic [20:0] c_TIMEOUT_LAST = 21'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_code_q;
  logic [20:0] r_cnt;
  logic [20:0] w_cnt_nxt;
  logic        r_held_jump_a, r_held_jump_b, r_held_duck, r_held_start, r_held_pause;
  logic        w_held_jump_a, w_held_jump_b, w_held_duck, w_held_start, w_held_pause;
  logic        w_new_byte;
  logic        w_decode;
  logic        w_ext;
  logic        w_brk;
  logic        w_jump_nxt;
  logic        w_start_nxt;
  logic        w_pause_nxt;
  logic        w_duck_nxt;

  assign w_new_byte = (code != r_code_q) && (code != 8'h00);

  // Prefix tracking and timeout; a real byte always wins over an expiring timer.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = 21'd0;
    w_decode    = 1'b0;
    w_ext       = 1'b0;
    w_brk       = 1'b0;

    if (r_state == ST_IDLE) begin
      if (w_new_byte) begin
        if (code == c_BYTE_EXT)      w_state_nxt = ST_EXT;
        else if (code == c_BYTE_BRK) w_state_nxt = ST_BRK;
        else                         w_decode    = 1'b1;
      end
    end else if (w_new_byte) begin
      case (r_state)
        ST_EXT: begin
          if (code == c_BYTE_BRK)      w_state_nxt = ST_EXT_BRK;
          else if (code != c_BYTE_EXT) begin
            w_state_nxt = ST_IDLE;
            w_decode    = 1'b1;
            w_ext       = 1'b1;
          end
        end
        ST_BRK: begin
          if (code == c_BYTE_EXT)      w_state_nxt = ST_EXT_BRK;
          else if (code != c_BYTE_BRK) begin
            w_state_nxt = ST_IDLE;
            w_decode    = 1'b1;
            w_brk       = 1'b1;
          end
        end
        default: begin
          if (code != c_BYTE_EXT && code != c_BYTE_BRK) begin
            w_state_nxt = ST_IDLE;
            w_decode    = 1'b1;
            w_ext       = 1'b1;
            w_brk       = 1'b1;
          end
        end
      endcase
    end else if (r_cnt == c_TIMEOUT_LAST) begin
      w_state_nxt = ST_IDLE;
    end else begin
      w_cnt_nxt = r_cnt + 21'd1;
    end
  end

  // Key map, held flags and command generation.
  always_comb begin
    w_held_jump_a = r_held_jump_a;
    w_held_jump_b = r_held_jump_b;
    w_held_duck   = r_held_duck;
    w_held_start  = r_held_start;
    w_held_pause  = r_held_pause;
    w_jump_nxt    = 1'b0;
    w_start_nxt   = 1'b0;
    w_pause_nxt   = pause;

    if (w_decode) begin
      if (!w_ext && code == c_KEY_SPACE) begin
        w_held_jump_a = !w_brk;
        if (!w_brk && !r_held_jump_a && !pause) w_jump_nxt = 1'b1;
      end
      if (w_ext && code == c_KEY_UP) begin
        w_held_jump_b = !w_brk;
        if (!w_brk && !r_held_jump_b && !pause) w_jump_nxt = 1'b1;
      end
      if (w_ext && code == c_KEY_DOWN) begin
        w_held_duck = !w_brk;
      end
      if (!w_ext && code == c_KEY_ENTER) begin
        w_held_start = !w_brk;
        if (!w_brk && !r_held_start) begin
          w_start_nxt = 1'b1;
          w_pause_nxt = 1'b0;
        end
      end
      if (!w_ext && code == c_KEY_P) begin
        w_held_pause = !w_brk;
        if (!w_brk && !r_held_pause) w_pause_nxt = !pause;
      end
    end

    w_duck_nxt = w_held_duck && !w_pause_nxt;
  end

  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_code_q      <= 8'h00;
      r_cnt         <= 21'd0;
      r_held_jump_a <= 1'b0;
      r_held_jump_b <= 1'b0;
      r_held_duck   <= 1'b0;
      r_held_start  <= 1'b0;
      r_held_pause  <= 1'b0;
      jump_pulse    <= 1'b0;
      duck_hold     <= 1'b0;
      start_pulse   <= 1'b0;
      pause         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_code_q      <= code;
      r_cnt         <= w_cnt_nxt;
      r_held_jump_a <= w_held_jump_a;
      r_held_jump_b <= w_held_jump_b;
      r_held_duck   <= w_held_duck;
      r_held_start  <= w_held_start;
      r_held_pause  <= w_held_pause;
      jump_pulse    <= w_jump_nxt;
      duck_hold     <= w_duck_nxt;
      start_pulse   <= w_start_nxt;
      pause         <= w_pause_nxt;
    end
  end

endmodule
`default_nettype wire

// File: doc/kb_cmd_decoder.md
KB_CMD_DECODER -- requirements
Module: kb_cmd_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1250000, meaning the cycles a prefix state may wait for its next byte before aborting (50 ms at 25 MHz).
REQ-002 SHALL have port VGA_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port code, input, 8 bits: scancode byte from the PS/2 receiver, held between frames, 0x00 means no byte.
REQ-005 SHALL have port jump_pulse, output, 1 bit: one-cycle jump command.
REQ-006 SHALL have port duck_hold, output, 1 bit: level, high while duck is requested.
REQ-007 SHALL have port start_pulse, output, 1 bit: one-cycle start/restart command.
REQ-008 SHALL have port pause, output, 1 bit: level, game-paused flag.

Function
REQ-009 SHALL register code into code_q every cycle.
REQ-010 SHALL define new_byte = (code != code_q) and (code != 0x00); identical consecutive non-zero values without an intervening change are one byte.
REQ-011 SHALL update FSM state and outputs on the edge ending the new_byte cycle, so latency is 1 cycle from the first cycle code shows the new value.
REQ-012 SHALL implement FSM states IDLE, BRK, EXT, EXT_BRK.
REQ-013 SHALL make these IDLE transitions: E0 -> EXT; F0 -> BRK; any other byte -> decode as a plain make, stay in IDLE.
REQ-014 SHALL make these EXT transitions: F0 -> EXT_BRK; E0 -> stay in EXT; other -> decode as an extended make, go to IDLE.
REQ-015 SHALL make these BRK transitions: E0 -> EXT_BRK; F0 -> stay in BRK; other -> decode as a plain break, go to IDLE.
REQ-016 SHALL make these EXT_BRK transitions: E0 or F0 -> stay; other -> decode as an extended break, go to IDLE.
REQ-017 SHALL use this key map: plain 0x29 (space) = JUMP_A; extended 0x75 (up) = JUMP_B; extended 0x72 (down) = DUCK; plain 0x5A (enter) = START; plain 0x4D (P) = PAUSE. All other codes are ignored, with the FSM still returning to IDLE.
REQ-018 SHALL keep a held flag per mapped key: set on make, cleared on break.
REQ-019 SHALL action a make only when that key's held flag was 0, so typematic repeats produce no further commands.
REQ-020 SHALL assert jump_pulse for exactly 1 cycle on an actioned JUMP_A or JUMP_B make when pause=0.
REQ-021 SHALL drive duck_hold = DUCK held flag AND NOT pause, registered.
REQ-022 SHALL assert start_pulse for 1 cycle on an actioned START make and clear pause in the same edge, regardless of pause.
REQ-023 SHALL toggle pause on an actioned PAUSE make.
REQ-024 SHALL still update held flags while paused; only commands are gated.
REQ-025 SHALL load a timeout counter (21 bits) with 0 on entry to any non-IDLE state, increment it each cycle without new_byte, and force IDLE with no decode when it reaches TIMEOUT-1.
REQ-026 SHALL hold the counter at 0 in IDLE.
REQ-027 SHALL give new_byte priority over timeout if both occur in the same cycle.
REQ-028 SHALL ignore 0x00 on code in every state; it neither advances the FSM nor resets the timeout.

Reset
REQ-029 SHALL, while reset=1, asynchronously force: state=IDLE; code_q=0x00; all held flags=0; counter=0; jump_pulse=0; duck_hold=0; start_pulse=0; pause=0.
REQ-030 SHALL, on reset asserted mid-sequence (e.g. after E0), discard the pending prefix; the first byte after release decodes from IDLE.

Verification
REQ-031 SHALL cover plain make and typematic repeat: code 0x29, then 0x00, then 0x29 -> jump_pulse high exactly 1 cycle, 1 cycle after the first 0x29, with no second pulse.
REQ-032 SHALL cover extended make and break: code E0, 72 -> duck_hold=1; then E0, F0, 72 -> duck_hold=0 one cycle after the 72.
REQ-033 SHALL cover pause gating: P make -> pause=1; then space make -> jump_pulse stays 0; then enter make -> start_pulse 1 cycle and pause=0 on the same edge.
REQ-034 SHALL cover timeout: code E0 followed by no byte for TIMEOUT cycles -> state IDLE; then 0x75 -> no jump_pulse (plain 0x75 is unmapped).
REQ-035 SHALL cover reset mid-sequence: F0, then reset pulse, then 0x29 -> jump_pulse asserted (treated as a make, not a break).
REQ-036 SHALL cover an unmapped byte: code 0x1C in IDLE -> all outputs unchanged and state stays IDLE.
